divider_rr_scheduler: RTL and testbench

//  Shares one divider core (Xin/Yin/Start/Ack/Done/Quotient/Remainder) between two requesters

---
 rtl/divider_rr_scheduler.sv | 135 +++++++++++++
 tb/tb_divider_rr_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_rr_scheduler.sv
// Round-robin front end for a single shared divider core: arbitrates two requesters,
// runs the core Start/Done/Ack handshake, short-circuits divide-by-zero and times each job.
module divider_rr_scheduler #(
  parameter int W     = 4,
  parameter int LAT_W = 8
) (
  input  logic             board_clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [W-1:0]     X0,
  input  logic [W-1:0]     Y0,
  input  logic [W-1:0]     X1,
  input  logic [W-1:0]     Y1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Rsp0,
  output logic             Rsp1,
  output logic [W-1:0]     Q,
  output logic [W-1:0]     R,
  output logic             DivZero,
  output logic [LAT_W-1:0] Lat,
  output logic             Busy,
  output logic [W-1:0]     DivXin,
  output logic [W-1:0]     DivYin,
  output logic             DivStart,
  output logic             DivAck,
  input  logic             DivDone,
  input  logic [W-1:0]     DivQuo,
  input  logic [W-1:0]     DivRem
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

  state_t           state_reg, state_next;
  logic             gsel_reg, gsel_next;
  logic             zero_reg, zero_next;
  logic             favour_reg;   // requester that wins when both ask
  logic             grant;
  logic [W-1:0]     win_x, win_y;
  logic [W-1:0]     x_reg, y_reg;
  logic [W-1:0]     q_reg, r_reg;
  logic             dz_reg;
  logic [LAT_W-1:0] lat_reg;
  logic             gnt0_reg, gnt1_reg, busy_reg;

  always_comb begin
    state_next = state_reg;
    gsel_next  = gsel_reg;
    zero_next  = zero_reg;
    grant      = 1'b0;
    win_x      = X0;
    win_y      = Y0;
    case (state_reg)
      IDLE: begin
        if (Req0 || Req1) begin
          grant     = 1'b1;
          gsel_next = (Req0 && Req1) ? favour_reg : Req1;
          win_x     = gsel_next ? X1 : X0;
          win_y     = gsel_next ? Y1 : Y0;
          zero_next = (win_y == '0);
          state_next = zero_next ? RESP : ISSUE;
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (DivDone) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      gsel_reg   <= 1'b0;
      zero_reg   <= 1'b0;
      favour_reg <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      q_reg      <= '0;
      r_reg      <= '0;
      dz_reg     <= 1'b0;
      lat_reg    <= '0;
      gnt0_reg   <= 1'b0;
      gnt1_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      gsel_reg  <= gsel_next;
      zero_reg  <= zero_next;
      // Gnt/Busy are registered copies of the next-state decode
      busy_reg  <= (state_next != IDLE);
      gnt0_reg  <= (state_next != IDLE) && !gsel_next;
      gnt1_reg  <= (state_next != IDLE) && gsel_next;
      if (grant) begin
        x_reg <= win_x;
        y_reg <= win_y;
      end
      if (grant && zero_next) begin
        q_reg   <= '1;
        r_reg   <= win_x;
        dz_reg  <= 1'b1;
        lat_reg <= '0;
      end
      if (state_reg == ISSUE) begin
        lat_reg <= '0;
      end else if (state_reg == WAIT) begin
        if (lat_reg != LAT_MAX) lat_reg <= lat_reg + LAT_W'(1);
        if (DivDone) begin
          q_reg  <= DivQuo;
          r_reg  <= DivRem;
          dz_reg <= 1'b0;
        end
      end
      if (state_reg == RESP) favour_reg <= ~gsel_reg;
    end
  end

  assign DivStart = (state_reg == ISSUE);
  assign DivAck   = (state_reg == RESP) && !zero_reg;
  assign Rsp0     = (state_reg == RESP) && !gsel_reg;
  assign Rsp1     = (state_reg == RESP) && gsel_reg;
  assign Gnt0     = gnt0_reg;
  assign Gnt1     = gnt1_reg;
  assign Busy     = busy_reg;
  assign Q        = q_reg;
  assign R        = r_reg;
  assign DivZero  = dz_reg;
  assign Lat      = lat_reg;
  assign DivXin   = x_reg;
  assign DivYin   = y_reg;

endmodule

// File: tb/tb_divider_rr_scheduler.sv
// Bench for divider_rr_scheduler: behavioural divider core, job-level reference model
// checked every cycle, directed scenarios with literal results, then random traffic.
module tb_divider_rr_scheduler;

  logic       board_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Req0 = 1'b0, Req1 = 1'b0;
  logic [3:0] X0 = '0, Y0 = '0, X1 = '0, Y1 = '0;
  logic       Gnt0, Gnt1, Rsp0, Rsp1, DivZero, Busy, DivStart, DivAck;
  logic [3:0] Q, R, DivXin, DivYin;
  logic [7:0] Lat;
  logic       DivDone;
  logic [3:0] DivQuo, DivRem;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  divider_rr_scheduler #(.W(4), .LAT_W(8)) dut (
    .board_clk(board_clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Rsp0(Rsp0), .Rsp1(Rsp1),
    .Q(Q), .R(R), .DivZero(DivZero), .Lat(Lat), .Busy(Busy),
    .DivXin(DivXin), .DivYin(DivYin), .DivStart(DivStart), .DivAck(DivAck),
    .DivDone(DivDone), .DivQuo(DivQuo), .DivRem(DivRem)
  );

  always #5 board_clk = ~board_clk;
  always @(posedge board_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider core stand-in: Done after a delay, held until Ack; garbage on outputs while computing.
  logic       core_busy;
  int         core_cnt;
  logic [3:0] cx, cy;
  int         core_delay = 1;
  bit         rand_delay = 1'b0;

  always @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      core_busy <= 1'b0; core_cnt <= 0; DivDone <= 1'b0;
      DivQuo <= '0; DivRem <= '0; cx <= '0; cy <= '0;
    end else if (core_busy) begin
      DivQuo <= 4'($urandom);
      DivRem <= 4'($urandom);
      if (core_cnt <= 1) begin
        core_busy <= 1'b0;
        DivDone   <= 1'b1;
        DivQuo    <= (cy == 0) ? 4'hF : cx / cy;
        DivRem    <= (cy == 0) ? cx : cx % cy;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end else if (DivDone) begin
      if (DivAck) DivDone <= 1'b0;
    end else if (DivStart) begin
      core_busy <= 1'b1;
      cx <= DivXin;
      cy <= DivYin;
      core_cnt <= rand_delay ? int'($urandom_range(1, 5)) : core_delay;
    end
  end

  // Reference model: one open job at a time, described by who, operands and grant cycle.
  bit         job_open = 1'b0, j_zero, done_seen, exp_rsp;
  int         j_sel, j_start, fav = 0;
  logic [3:0] j_x, j_y;

  always @(negedge board_clk) begin
    if (Reset) begin
      chk("rst_ctrl", int'({Busy, Gnt0, Gnt1, Rsp0, Rsp1, DivStart, DivAck, DivZero}), 0);
      chk("rst_q", int'(Q), 0);
      chk("rst_r", int'(R), 0);
      chk("rst_lat", int'(Lat), 0);
      job_open = 1'b0;
      fav = 0;
    end else if (!job_open) begin
      chk("idle_ctrl", int'({Busy, Gnt0, Gnt1, Rsp0, Rsp1, DivStart, DivAck}), 0);
      if (Req0 || Req1) begin
        j_sel     = (Req0 && Req1) ? fav : (Req1 ? 1 : 0);
        j_x       = (j_sel == 1) ? X1 : X0;
        j_y       = (j_sel == 1) ? Y1 : Y0;
        j_zero    = (j_y == 0);
        j_start   = cyc + 1;
        done_seen = 1'b0;
        job_open  = 1'b1;
      end
    end else begin
      exp_rsp = j_zero ? (cyc == j_start) : done_seen;
      chk("busy", int'(Busy), 1);
      chk("gnt0", int'(Gnt0), int'(j_sel == 0));
      chk("gnt1", int'(Gnt1), int'(j_sel == 1));
      chk("rsp0", int'(Rsp0), int'(exp_rsp && j_sel == 0));
      chk("rsp1", int'(Rsp1), int'(exp_rsp && j_sel == 1));
      chk("start", int'(DivStart), int'(!j_zero && cyc == j_start));
      chk("ack", int'(DivAck), int'(exp_rsp && !j_zero));
      if (!j_zero) begin
        chk("xin", int'(DivXin), int'(j_x));
        chk("yin", int'(DivYin), int'(j_y));
      end
      if (exp_rsp) begin
        chk("q", int'(Q), j_zero ? 15 : int'(j_x / j_y));
        chk("r", int'(R), j_zero ? int'(j_x) : int'(j_x % j_y));
        chk("divzero", int'(DivZero), int'(j_zero));
        chk("lat", int'(Lat), j_zero ? 0 : cyc - j_start - 1);
        job_open = 1'b0;
        fav = 1 - j_sel;
      end else begin
        if (!j_zero && cyc > j_start && DivDone) done_seen = 1'b1;
        if (cyc - j_start > 150) begin
          chk("job_timeout", cyc - j_start, 150);
          job_open = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic set_req(input int who, input logic v, input logic [3:0] x, input logic [3:0] y);
    if (who == 0) begin Req0 = v; X0 = x; Y0 = y; end
    else begin Req1 = v; X1 = x; Y1 = y; end
  endtask

  task automatic wait_rsp(input int who, output int n, output int starts, output int ack);
    bit ok = 1'b0;
    n = 0; starts = 0; ack = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge board_clk);
      n++;
      if (DivStart) starts++;
      if ((who == 0) ? Rsp0 : Rsp1) begin
        ok = 1'b1;
        ack = int'(DivAck);
      end
    end
    if (!ok) chk("rsp_timeout", who, -1);
  endtask

  task automatic wait_any(output int who);
    bit ok = 1'b0;
    who = -1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge board_clk);
      if (Rsp0 || Rsp1) begin
        ok = 1'b1;
        who = Rsp1 ? 1 : 0;
      end
    end
    if (!ok) chk("any_rsp_timeout", 0, 1);
  endtask

  task automatic wait_start();
    bit ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge board_clk);
      if (DivStart) ok = 1'b1;
    end
    if (!ok) chk("start_timeout", 0, 1);
  endtask

  task automatic rand_requester(input int who, input int jobs);
    int n, s, a;
    logic [3:0] x, y;
    for (int k = 0; k < jobs; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      x = 4'($urandom);
      y = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      set_req(who, 1'b1, x, y);
      wait_rsp(who, n, s, a);
      tick();
      set_req(who, 1'b0, x, y);
    end
  endtask

  initial begin
    int n, s, a, who;
    repeat (3) tick();
    Reset = 1'b0;

    // Single core job 13/4
    core_delay = 1;
    tick();
    set_req(0, 1'b1, 4'd13, 4'd4);
    wait_rsp(0, n, s, a);
    chk("t1_q", int'(Q), 3);
    chk("t1_r", int'(R), 1);
    chk("t1_dz", int'(DivZero), 0);
    chk("t1_lat_pos", int'(Lat > 0), 1);
    chk("t1_starts", s, 1);
    chk("t1_ack", a, 1);
    chk("t1_cycles", n, 5);
    tick();
    set_req(0, 1'b0, 4'd13, 4'd4);

    // Simultaneous requests after reset: requester 0 first
    do_reset();
    core_delay = 2;
    tick();
    set_req(0, 1'b1, 4'd9, 4'd2);
    set_req(1, 1'b1, 4'd15, 4'd5);
    wait_rsp(0, n, s, a);
    chk("t2_q0", int'(Q), 4);
    chk("t2_r0", int'(R), 1);
    tick();
    set_req(0, 1'b0, 4'd9, 4'd2);
    wait_rsp(1, n, s, a);
    chk("t2_q1", int'(Q), 3);
    chk("t2_r1", int'(R), 0);
    tick();
    set_req(1, 1'b0, 4'd15, 4'd5);

    // Both held for four jobs: strict alternation starting at 0
    tick();
    set_req(0, 1'b1, 4'd8, 4'd3);
    set_req(1, 1'b1, 4'd10, 4'd4);
    for (int k = 0; k < 4; k++) begin
      wait_any(who);
      chk("t3_order", who, k % 2);
    end
    tick();
    set_req(0, 1'b0, 4'd8, 4'd3);
    set_req(1, 1'b0, 4'd10, 4'd4);

    // Divide by zero never reaches the core
    tick();
    set_req(1, 1'b1, 4'd7, 4'd0);
    wait_rsp(1, n, s, a);
    chk("t4_cycles", n, 2);
    chk("t4_starts", s, 0);
    chk("t4_ack", a, 0);
    chk("t4_q", int'(Q), 15);
    chk("t4_r", int'(R), 7);
    chk("t4_dz", int'(DivZero), 1);
    chk("t4_lat", int'(Lat), 0);
    tick();
    set_req(1, 1'b0, 4'd7, 4'd0);

    // Req1 arrives while Req0's job is in flight
    core_delay = 4;
    tick();
    set_req(0, 1'b1, 4'd12, 4'd5);
    wait_start();
    tick();
    set_req(1, 1'b1, 4'd11, 4'd3);
    wait_rsp(0, n, s, a);
    chk("t6_q0", int'(Q), 2);
    chk("t6_r0", int'(R), 2);
    tick();
    set_req(0, 1'b0, 4'd12, 4'd5);
    wait_rsp(1, n, s, a);
    chk("t6_q1", int'(Q), 3);
    chk("t6_r1", int'(R), 2);
    tick();
    set_req(1, 1'b0, 4'd11, 4'd3);

    // Reset during WAIT, then a normal job
    core_delay = 6;
    tick();
    set_req(0, 1'b1, 4'd13, 4'd4);
    wait_start();
    tick();
    tick();
    Reset = 1'b1;
    set_req(0, 1'b0, 4'd13, 4'd4);
    #1;
    chk("t5_busy", int'(Busy), 0);
    chk("t5_gnt", int'({Gnt0, Gnt1}), 0);
    chk("t5_q", int'(Q), 0);
    chk("t5_r", int'(R), 0);
    tick();
    tick();
    Reset = 1'b0;
    core_delay = 2;
    tick();
    set_req(0, 1'b1, 4'd14, 4'd3);
    wait_rsp(0, n, s, a);
    chk("t5_q_after", int'(Q), 4);
    chk("t5_r_after", int'(R), 2);
    tick();
    set_req(0, 1'b0, 4'd14, 4'd3);

    // Random traffic from both requesters
    rand_delay = 1'b1;
    fork
      rand_requester(0, 20);
      rand_requester(1, 20);
    join
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
